// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one multi-cycle ALU between two requesters.
// One operation in flight; the result is returned tagged with the requester id.
module alu_share_ctrl #(
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned MAX_FUNC = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_func,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_sh,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_func,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_sh,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_res1,
  output logic [31:0] rsp_res2,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [31:0] alu_inp1,
  output logic [31:0] alu_inp2,
  output logic [5:0]  alu_func,
  output logic [5:0]  alu_shAmt,
  output logic        alu_ena,
  input  logic [31:0] alu_res1,
  input  logic [31:0] alu_res2,
  input  logic [3:0]  alu_flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);
  localparam logic [5:0] FUNC_MAX = 6'(MAX_FUNC);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        grant, rdy0, rdy1, accept, illegal;
  logic [5:0]  sel_func, sel_sh;
  logic [31:0] sel_a, sel_b;
  logic [5:0]  func_q, sh_q;
  logic [31:0] a_q, b_q;
  logic [3:0]  cnt_q;
  logic        id_q, err_q;
  logic [31:0] res1_q, res2_q;
  logic [3:0]  flags_q;

  // A tie goes to the requester that did not win last time.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves the signal unassigned (avoids a latch).
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
  end

  assign rdy0     = (state_q == IDLE) && req0_valid && !grant;
  assign rdy1     = (state_q == IDLE) && req1_valid && grant;
  assign accept   = rdy0 || rdy1;
  assign sel_func = grant ? req1_func : req0_func;
  assign sel_a    = grant ? req1_a    : req0_a;
  assign sel_b    = grant ? req1_b    : req0_b;
  assign sel_sh   = grant ? req1_sh   : req0_sh;
  assign illegal  = sel_func > FUNC_MAX;

  // Ready is forced low while reset is held, even if a requester is already valid.
  assign req0_ready = rdy0 && rst_n;
  assign req1_ready = rdy1 && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = illegal ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_ena   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ISSUE:   alu_ena   = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      func_q       <= '0;
      sh_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      res1_q       <= '0;
      res2_q       <= '0;
      flags_q      <= '0;
    end else begin
      if (accept) begin
        func_q       <= sel_func;
        a_q          <= sel_a;
        b_q          <= sel_b;
        sh_q         <= sel_sh;
        id_q         <= grant;
        last_grant_q <= grant;
        // Illegal codes bypass the ALU and answer with an error and a zero payload.
        if (illegal) begin
          res1_q  <= '0;
          res2_q  <= '0;
          flags_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_INIT;
      end else if (state_q == WAIT) begin
        if (cnt_q == '0) begin
          res1_q  <= alu_res1;
          res2_q  <= alu_res2;
          flags_q <= alu_flags;
          err_q   <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  // ALU inputs come straight from the latch registers, so they only move on accept.
  assign alu_inp1  = a_q;
  assign alu_inp2  = b_q;
  assign alu_func  = func_q;
  assign alu_shAmt = sh_q;

  assign rsp_id    = id_q;
  assign rsp_res1  = res1_q;
  assign rsp_res2  = res2_q;
  assign rsp_flags = flags_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-port arbiter and sequencer that shares the single ALU_unit between two requesters, such as the execute stage and a multi-cycle helper.
- Each requester hands over one operation (func, operands, shift amount) on a valid/ready handshake.
- The block picks a requester round-robin, pulses the ALU enable, holds the operands stable, and captures res1/res2/flags after a fixed latency.
- It returns the result, tagged with the requester id, on a single valid/ready response channel.

Parameters:
- ALU_LAT, 1, cycles between the ALU enable pulse and result capture (legal range 1..15).
- MAX_FUNC, 11, highest legal func code; a larger code is an illegal operation.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle (when valid)
- req0_func  in  6  ALU func code
- req0_a  in  32  operand 1
- req0_b  in  32  operand 2
- req0_sh  in  6  shift amount
- req1_valid, req1_ready, req1_func, req1_a, req1_b, req1_sh  same as port 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester id of the response
- rsp_res1  out  32  captured ALU res1
- rsp_res2  out  32  captured ALU res2
- rsp_flags  out  4  {carry, sign, overflow, zero}
- rsp_err  out  1  illegal func
- alu_inp1, alu_inp2  out  32  driven to ALU inp1/inp2
- alu_func  out  6  driven to ALU func
- alu_shAmt  out  6  driven to ALU shAmt
- alu_ena  out  1  ALU enable
- alu_res1, alu_res2  in  32  ALU results
- alu_flags  in  4  ALU flags, same order as rsp_flags

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - State returns to IDLE.
  - All outputs are 0, including alu_ena, rsp_valid, req*_ready and all data outputs.
  - last_grant is set to 1, so requester 0 wins the first tie.
  - Any in-flight operation is discarded; no response is produced for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid.
  - If both are valid, grant goes to the requester not equal to last_grant.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational; at most one ready is high, never both.
  - On accept (valid && ready): latch func/a/b/sh and id, update last_grant, go to ISSUE.
  - If the latched func > MAX_FUNC: skip the ALU and go directly to RESP with rsp_err=1, res1=res2=0, flags=0.
- ISSUE (1 cycle):
  - alu_ena=1; alu_inp1/alu_inp2/alu_func/alu_shAmt driven from the latched values.
  - Load the WAIT counter with ALU_LAT-1; go to WAIT.
- WAIT:
  - alu_ena=0; ALU inputs remain held.
  - Counter decrements each cycle.
  - At count 0: capture alu_res1/res2/flags into rsp_* registers, rsp_err=0, go to RESP.
- RESP:
  - rsp_valid=1 with stable payload until rsp_valid && rsp_ready; then go to IDLE.
  - No new request is accepted while in RESP; ready is only asserted in IDLE.
- ALU inputs:
  - Hold their last latched values in all non-ISSUE states, so no spurious toggles reach the ALU.
  - alu_ena is high for exactly one cycle per legal operation.
- Latency for a legal op: accept at edge t; rsp_valid high from edge t+2+ALU_LAT. ALU_LAT=1 gives 3 cycles.
- Latency for an illegal op: rsp_valid high from edge t+1.
- Throughput: one op per 3+ALU_LAT cycles when rsp_ready is held high (accept cycle, ISSUE, ALU_LAT WAIT cycles, RESP).
- A requester dropping valid without being accepted is legal; no state change results.
- A requester changing its payload while valid and not ready is legal; the value sampled on the accept edge is used.

Test Plan:
- req0: func=0, a=12, b=34, ALU_LAT=1, rsp_ready=1 -> alu_ena one cycle; rsp_valid 3 cycles after accept; rsp_id=0, rsp_res1=46, rsp_flags=0000, rsp_err=0.
- req0 and req1 valid every cycle from reset (req0 func=4 a=3 b=2; req1 func=5 a=3 b=2) -> grants alternate 0,1,0,1; responses res1=2 (id 0) and 1 (id 1) alternate; never two readys together.
- req1: func=6, a=42, sh=3; rsp_ready held 0 for 5 cycles -> rsp_valid and res1=336 stay stable; req0_valid during this time is not accepted until the cycle after rsp_ready rises.
- req0: func=12 -> no alu_ena pulse; rsp_valid 1 cycle after accept with rsp_err=1, res1=res2=0, flags=0.
- rst_n pulled low during WAIT of func=0, a=b=0xFFFFFFFF -> all outputs 0 immediately (no clock edge); after release the next tie grants req0; no stale response appears.
- ALU_LAT=3, func=11, a=0xFFFFFFFF, b=5 -> capture at the end of the third WAIT cycle; rsp_valid 5 cycles after accept; res1=0xFFFFFFFF.
